// File: rtl/jtcop_vram_arb_pkg.sv
// rtl/jtcop_vram_arb_pkg.sv - shared constants, FSM encoding and round-robin helper for the VRAM arbiter
package jtcop_arb_pkg;

    localparam int NSLOTS   = 4;
    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_DST = 2'd2,
        ST_WAIT_RDY = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // First pending slot searching upward from last+1, wrapping mod 4; the
    // last granted slot itself is considered only after the other three.
    function automatic rr_pick_t rr_pick(input logic [NSLOTS-1:0] pend, input logic [1:0] last);
        rr_pick_t   r;
        logic [1:0] c;
        r = '0;
        for (int i = NSLOTS; i >= 1; i--) begin
            c = last + 2'(i);
            if (pend[c]) begin
                r.found = 1'b1;
                r.idx   = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jtcop_vram_arb_if.sv
// rtl/jtcop_vram_arb_if.sv - SDRAM request/response bus between the arbiter and the memory controller
interface jtcop_vram_arb_if;
    import jtcop_arb_pkg::*;

    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_rd;
    logic                sdram_wr;
    logic [15:0]         data_write;
    logic [1:0]          sdram_wrmask;
    logic                sdram_ack;
    logic                data_dst;
    logic                data_rdy;
    logic [15:0]         data_read;

    modport master (
        output sdram_addr, sdram_rd, sdram_wr, data_write, sdram_wrmask,
        input  sdram_ack, data_dst, data_rdy, data_read
    );

    modport slave (
        input  sdram_addr, sdram_rd, sdram_wr, data_write, sdram_wrmask,
        output sdram_ack, data_dst, data_rdy, data_read
    );

endinterface

// File: rtl/jtcop_slot_cache.sv
// rtl/jtcop_slot_cache.sv - one-word tag/data/valid cache with hit compare and registered ok
module jtcop_slot_cache #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  logic          clr,
    input  logic          fill_dst,
    input  logic          fill_rdy,
    input  logic [AW-1:0] fill_tag,
    input  logic [15:0]   fill_data,
    input  logic          wr_upd,
    input  logic [15:0]   wr_data,
    input  logic [1:0]    wr_mask,
    input  logic          wr_ok,
    output logic [15:0]   dout,
    output logic          hit,
    output logic          ok
);

    logic [AW-1:0] tag_q, tag_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          ok_q, ok_d;

    assign hit  = rd_en & valid_q & (tag_q == addr);
    assign dout = data_q;
    assign ok   = ok_q;

    // Next cache contents; data lands on dst but only becomes valid on rdy,
    // and ok is registered from the post-update hit so it rises right after rdy.
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (fill_dst) begin
            tag_d   = fill_tag;
            data_d  = fill_data;
            valid_d = 1'b0;
        end
        if (fill_rdy) begin
            valid_d = 1'b1;
        end
        if (wr_upd && valid_q && (tag_q == fill_tag)) begin
            data_d[7:0]  = wr_mask[0] ? data_q[7:0]  : wr_data[7:0];
            data_d[15:8] = wr_mask[1] ? data_q[15:8] : wr_data[15:8];
        end
        if (clr) begin
            valid_d = 1'b0;
        end
        ok_d = (rd_en & valid_d & (tag_d == addr)) | wr_ok;
    end

    // Cache state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: rtl/jtcop_vram_arb.sv
// rtl/jtcop_vram_arb.sv - four-slot round-robin SDRAM arbiter with one-word per-slot caches
module jtcop_vram_arb
    import jtcop_arb_pkg::*;
#(
    parameter int SLOT0_AW = 15,
    parameter int SLOTN_AW = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                slot0_cs,
    input  logic                slot1_cs,
    input  logic                slot2_cs,
    input  logic                slot3_cs,
    input  logic [SLOT0_AW-1:0] slot0_addr,
    input  logic [SLOTN_AW-1:0] slot1_addr,
    input  logic [SLOTN_AW-1:0] slot2_addr,
    input  logic [SLOTN_AW-1:0] slot3_addr,
    input  logic [SDRAM_AW-1:0] offset0,
    input  logic [SDRAM_AW-1:0] offset1,
    input  logic [SDRAM_AW-1:0] offset2,
    input  logic [SDRAM_AW-1:0] offset3,
    input  logic                slot0_wen,
    input  logic [15:0]         slot0_din,
    input  logic [1:0]          slot0_wrmask,
    input  logic                slot0_clr,
    input  logic                slot1_clr,
    input  logic                slot2_clr,
    input  logic                slot3_clr,
    output logic [15:0]         slot0_dout,
    output logic [15:0]         slot1_dout,
    output logic [15:0]         slot2_dout,
    output logic [15:0]         slot3_dout,
    output logic                slot0_ok,
    output logic                slot1_ok,
    output logic                slot2_ok,
    output logic                slot3_ok,
    jtcop_vram_arb_if.master    sdram
);

    localparam int LAW = (SLOT0_AW > SLOTN_AW) ? SLOT0_AW : SLOTN_AW;

    logic [NSLOTS-1:0]   cs_v, clr_v, hit, pend, fill_dst, fill_rdy;
    logic [LAW-1:0]      addr_v [NSLOTS];
    logic [SDRAM_AW-1:0] offs_v [NSLOTS];
    rr_pick_t            pick;
    logic                wr_cpl;

    arb_state_t          state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          gnt_q, gnt_d;
    logic                is_wr_q, is_wr_d;
    logic [LAW-1:0]      lat_addr_q, lat_addr_d;
    logic                discard_q, discard_d;
    logic                wr_done_q, wr_done_d;
    logic [SLOT0_AW-1:0] wr_addr_q, wr_addr_d;
    logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [15:0]         data_write_q, data_write_d;
    logic [1:0]          wrmask_q, wrmask_d;

    assign sdram.sdram_addr   = sdram_addr_q;
    assign sdram.sdram_rd     = rd_q;
    assign sdram.sdram_wr     = wr_q;
    assign sdram.data_write   = data_write_q;
    assign sdram.sdram_wrmask = wrmask_q;

    // Gather the per-slot inputs into indexable vectors.
    always_comb begin
        cs_v      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
        clr_v     = {slot3_clr, slot2_clr, slot1_clr, slot0_clr};
        addr_v[0] = LAW'(slot0_addr);
        addr_v[1] = LAW'(slot1_addr);
        addr_v[2] = LAW'(slot2_addr);
        addr_v[3] = LAW'(slot3_addr);
        offs_v[0] = offset0;
        offs_v[1] = offset1;
        offs_v[2] = offset2;
        offs_v[3] = offset3;
    end

    // Arbiter FSM next state: grant, request hold, fill and write completion.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        is_wr_d      = is_wr_q;
        lat_addr_d   = lat_addr_q;
        discard_d    = discard_q;
        wr_done_d    = wr_done_q;
        wr_addr_d    = wr_addr_q;
        sdram_addr_d = sdram_addr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        data_write_d = data_write_q;
        wrmask_d     = wrmask_q;
        fill_dst     = '0;
        fill_rdy     = '0;
        wr_cpl       = 1'b0;

        pend    = cs_v & ~hit;
        pend[0] = slot0_wen ? (slot0_cs & ~wr_done_q) : (slot0_cs & ~hit[0]);
        pick    = rr_pick(pend, last_q);

        // A completed write is remembered only while the same access is held.
        if (!slot0_cs || (slot0_addr != wr_addr_q)) begin
            wr_done_d = 1'b0;
        end
        // Invalidate of the slot being served: its fill must not become valid.
        if ((state_q != ST_IDLE) && clr_v[gnt_q]) begin
            discard_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    gnt_d        = pick.idx;
                    last_d       = pick.idx;
                    lat_addr_d   = addr_v[pick.idx];
                    discard_d    = 1'b0;
                    sdram_addr_d = offs_v[pick.idx] + SDRAM_AW'(addr_v[pick.idx]);
                    if ((pick.idx == 2'd0) && slot0_wen) begin
                        wr_d         = 1'b1;
                        is_wr_d      = 1'b1;
                        data_write_d = slot0_din;
                        wrmask_d     = slot0_wrmask;
                    end else begin
                        rd_d    = 1'b1;
                        is_wr_d = 1'b0;
                    end
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (sdram.sdram_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = is_wr_q ? ST_WAIT_RDY : ST_WAIT_DST;
                end
            end
            ST_WAIT_DST: begin
                if (sdram.data_dst) begin
                    fill_dst[gnt_q] = 1'b1;
                    state_d         = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (sdram.data_rdy) begin
                    state_d = ST_IDLE;
                    if (is_wr_q) begin
                        wr_cpl    = 1'b1;
                        wr_done_d = 1'b1;
                        wr_addr_d = lat_addr_q[SLOT0_AW-1:0];
                    end else if (!discard_d) begin
                        fill_rdy[gnt_q] = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 2'd3;
            gnt_q        <= 2'd0;
            is_wr_q      <= 1'b0;
            lat_addr_q   <= '0;
            discard_q    <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_addr_q    <= '0;
            sdram_addr_q <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            data_write_q <= '0;
            wrmask_q     <= 2'b11;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            is_wr_q      <= is_wr_d;
            lat_addr_q   <= lat_addr_d;
            discard_q    <= discard_d;
            wr_done_q    <= wr_done_d;
            wr_addr_q    <= wr_addr_d;
            sdram_addr_q <= sdram_addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            data_write_q <= data_write_d;
            wrmask_q     <= wrmask_d;
        end
    end

    jtcop_slot_cache #(.AW(SLOT0_AW)) u_cache0 (
        .clk(clk), .rst_n(rst_n), .rd_en(slot0_cs & ~slot0_wen), .addr(slot0_addr),
        .clr(slot0_clr), .fill_dst(fill_dst[0]), .fill_rdy(fill_rdy[0]),
        .fill_tag(lat_addr_q[SLOT0_AW-1:0]), .fill_data(sdram.data_read),
        .wr_upd(wr_cpl), .wr_data(data_write_q), .wr_mask(wrmask_q),
        .wr_ok(wr_cpl & slot0_cs & slot0_wen),
        .dout(slot0_dout), .hit(hit[0]), .ok(slot0_ok)
    );

    jtcop_slot_cache #(.AW(SLOTN_AW)) u_cache1 (
        .clk(clk), .rst_n(rst_n), .rd_en(slot1_cs), .addr(slot1_addr),
        .clr(slot1_clr), .fill_dst(fill_dst[1]), .fill_rdy(fill_rdy[1]),
        .fill_tag(lat_addr_q[SLOTN_AW-1:0]), .fill_data(sdram.data_read),
        .wr_upd(1'b0), .wr_data(16'h0000), .wr_mask(2'b11), .wr_ok(1'b0),
        .dout(slot1_dout), .hit(hit[1]), .ok(slot1_ok)
    );

    jtcop_slot_cache #(.AW(SLOTN_AW)) u_cache2 (
        .clk(clk), .rst_n(rst_n), .rd_en(slot2_cs), .addr(slot2_addr),
        .clr(slot2_clr), .fill_dst(fill_dst[2]), .fill_rdy(fill_rdy[2]),
        .fill_tag(lat_addr_q[SLOTN_AW-1:0]), .fill_data(sdram.data_read),
        .wr_upd(1'b0), .wr_data(16'h0000), .wr_mask(2'b11), .wr_ok(1'b0),
        .dout(slot2_dout), .hit(hit[2]), .ok(slot2_ok)
    );

    jtcop_slot_cache #(.AW(SLOTN_AW)) u_cache3 (
        .clk(clk), .rst_n(rst_n), .rd_en(slot3_cs), .addr(slot3_addr),
        .clr(slot3_clr), .fill_dst(fill_dst[3]), .fill_rdy(fill_rdy[3]),
        .fill_tag(lat_addr_q[SLOTN_AW-1:0]), .fill_data(sdram.data_read),
        .wr_upd(1'b0), .wr_data(16'h0000), .wr_mask(2'b11), .wr_ok(1'b0),
        .dout(slot3_dout), .hit(hit[3]), .ok(slot3_ok)
    );

endmodule

// File: doc/jtcop_vram_arb.md
JTCOP_VRAM_ARB -- requirements
Module: jtcop_vram_arb

Interface
REQ-001 Parameter SLOT0_AW, default 15, slot 0 word-address width (main RAM/VRAM, read/write).
REQ-002 Parameter SLOTN_AW, default 12, word-address width of read-only slots 1..3 (BAC06 tilemap readers).
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 slotK_cs  in  1 (K=0..3)  request from slot K.
REQ-006 slot0_addr  in  SLOT0_AW; slot1_addr..slot3_addr  in  SLOTN_AW  word addresses.
REQ-007 offsetK  in  22 (K=0..3)  SDRAM word offset added to slot address.
REQ-008 slot0_wen  in  1; slot0_din  in  16; slot0_wrmask  in  2 (active-low byte mask).
REQ-009 slotK_clr  in  1  invalidate slot K cache.
REQ-010 slotK_dout  out  16; slotK_ok  out  1.
REQ-011 sdram_addr  out  22; sdram_rd  out  1; sdram_wr  out  1; data_write  out  16; sdram_wrmask  out  2.
REQ-012 sdram_ack  in  1; data_dst  in  1; data_rdy  in  1; data_read  in  16.

Function
REQ-013 Each slot SHALL keep a one-word cache: tag (latched address), data, valid.
REQ-014 Read hit = cs & valid & tag==current address; slotK_ok SHALL be registered hit (one cycle after hit condition), slotK_dout = cached data.
REQ-015 FSM states IDLE, WAIT_ACK, WAIT_DST, WAIT_RDY; reset to IDLE.
REQ-016 IDLE: pending slots = cs & ~hit (slot 0 write: cs & wen & ~wr_done); grant SHALL be round-robin starting at last grant+1, mod 4.
REQ-017 On grant: latch slot index and address; sdram_addr = offsetK + zero-extended address (22-bit, wrap modulo 2^22); assert sdram_rd (or sdram_wr, data_write=slot0_din, sdram_wrmask=slot0_wrmask for slot-0 write); go WAIT_ACK.
REQ-018 WAIT_ACK: hold rd/wr and address stable until sdram_ack; on ack drop rd/wr same edge; read -> WAIT_DST, write -> WAIT_RDY.
REQ-019 WAIT_DST: on data_dst capture data_read into granted slot cache data, tag = latched address; -> WAIT_RDY.
REQ-020 WAIT_RDY: on data_rdy set valid (read) or wr_done plus cache update with written word (write, masked bytes retain old data) ; -> IDLE; earliest next grant is the following cycle.
REQ-021 wr_done SHALL clear when slot0_cs low or slot0_addr differs from tag; a write SHALL occur exactly once per cs assertion/address.
REQ-022 Slot-0 write completion SHALL assert slot0_ok one cycle after data_rdy while cs & wen remain.
REQ-023 Address or cs change during a transaction: transaction completes with latched address; ok reflects hit test against current inputs only.
REQ-024 slotK_clr in any state SHALL clear valid for K; if K is mid-read, the fill on data_rdy SHALL be discarded.
REQ-025 A slot-0 write to an address hitting any cache of slot 0 updates it; other slots' caches not snooped (disjoint regions).
REQ-026 Only one outstanding SDRAM transaction at any time; sdram_rd & sdram_wr never both high.

Reset
REQ-027 On rst_n low: state IDLE, last grant = 3 (slot 0 first), all valid/wr_done 0, all ok 0, sdram_rd/wr 0, sdram_addr/data_write 0, sdram_wrmask 2'b11, dout 0.
REQ-028 Reset asserted mid-transaction SHALL abort immediately; late ack/dst/rdy after reset release in IDLE SHALL be ignored.

Structure
REQ-029 FSM state encoding and slot-count constant SHALL live in shared package jtcop_arb_pkg.
REQ-030 Per-slot cache (tag/data/valid/hit compare) SHALL be one sub-module, jtcop_slot_cache, instantiated four times.

Verification
REQ-031 Slot1 read addr 0x012, offset1 0x102000, SDRAM returns 0xBEEF -> sdram_addr 0x102012, slot1_dout 0xBEEF, slot1_ok one cycle after data_rdy.
REQ-032 All four cs high, distinct misses, from reset -> grants 0,1,2,3 in order; repeat with new addresses -> order 0,1,2,3 again.
REQ-033 Slot0 write 0x1234 mask 2'b01 to 0x0040 held 20 cycles -> exactly one sdram_wr, sdram_wrmask 2'b01, slot0_ok once.
REQ-034 Same address re-read by slot 2 after fill -> slot2_ok next cycle, no sdram_rd.
REQ-035 slot3_clr pulsed during WAIT_DST of slot 3 read -> slot3_ok stays 0, next cycle re-request issued.
REQ-036 rst_n low in WAIT_ACK -> sdram_rd 0 asynchronously, all ok 0, first grant after release slot 0.
